// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with programmable terminal value,
// synchronous load, wrap pulse and sticky error flag.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-low reset
//   en       count enable, one step per enabled edge
//   up       direction: 1 up, 0 down
//   load     parallel load request (priority over en)
//   load_val BCD value to load, digit 0 in [3:0]
//   limit    BCD terminal value, count range 0..limit
//   counter  registered BCD count
//   tc       registered wrap pulse
//   err      sticky error flag, cleared only by reset
module bcd_updown_counter #(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic [4*DIGITS-1:0]   limit,
  output logic [4*DIGITS-1:0]   counter,
  output logic                  tc,
  output logic                  err
);

  localparam int W = 4 * DIGITS;

  logic         lim_bad;
  logic         val_bad;
  logic [W-1:0] inc_val;
  logic [W-1:0] dec_val;
  logic [W-1:0] cnt_nxt;
  logic         tc_nxt;
  logic         err_nxt;

  always_comb begin
    lim_bad = 1'b0;
    val_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (limit[4*i +: 4] > 4'd9)
        lim_bad = 1'b1;
      if (load_val[4*i +: 4] > 4'd9)
        val_bad = 1'b1;
    end
  end

  // Digit-wise ripple carry/borrow across the whole count.
  always_comb begin
    logic       carry;
    logic       borrow;
    logic [3:0] d;
    carry   = 1'b1;
    borrow  = 1'b1;
    inc_val = '0;
    dec_val = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d = counter[4*i +: 4];
      if (carry) begin
        if (d == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = d + 4'd1;
          carry = 1'b0;
        end
      end else begin
        inc_val[4*i +: 4] = d;
      end
      if (borrow) begin
        if (d == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = d - 4'd1;
          borrow = 1'b0;
        end
      end else begin
        dec_val[4*i +: 4] = d;
      end
    end
  end

  // Valid BCD buses order the same as plain unsigned vectors,
  // so magnitude compares use the packed value directly.
  always_comb begin
    cnt_nxt = counter;
    tc_nxt  = 1'b0;
    err_nxt = err;
    if ((load || en) && lim_bad) begin
      err_nxt = 1'b1;
    end else if (load) begin
      if (!val_bad && (load_val <= limit))
        cnt_nxt = load_val;
      else
        err_nxt = 1'b1;
    end else if (en) begin
      if (up) begin
        if (counter >= limit) begin
          cnt_nxt = '0;
          tc_nxt  = 1'b1;
        end else begin
          cnt_nxt = inc_val;
        end
      end else begin
        if (counter == '0) begin
          cnt_nxt = limit;
          tc_nxt  = 1'b1;
        end else begin
          cnt_nxt = dec_val;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      counter <= '0;
      tc      <= 1'b0;
      err     <= 1'b0;
    end else begin
      counter <= cnt_nxt;
      tc      <= tc_nxt;
      err     <= err_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter, DIGITS=2.
// Table vectors plus looped wrap sequences.
module tb_bcd_updown_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] limit;
  logic [7:0] counter;
  logic       tc;
  logic       err;

  int checks;
  int errors;

  bcd_updown_counter #(.DIGITS(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .counter  (counter),
    .tc       (tc),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       e;
    logic       u;
    logic       l;
    logic [7:0] lv;
    logic [7:0] lim;
    logic [7:0] ec;
    logic       et;
    logic       ee;
  } vec_t;

  vec_t vecs [36];

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  task automatic step(input logic r, input logic e,
                      input logic u, input logic l,
                      input logic [7:0] lv,
                      input logic [7:0] lim);
    @(negedge clk);
    reset    = r;
    en       = e;
    up       = u;
    load     = l;
    load_val = lv;
    limit    = lim;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm,
                       input logic [7:0] ec,
                       input logic et,
                       input logic ee);
    checks++;
    if (counter !== ec || tc !== et || err !== ee) begin
      errors++;
      $display("FAIL %s: got cnt=%h tc=%b err=%b want cnt=%h tc=%b err=%b",
               nm, counter, tc, err, ec, et, ee);
    end
  endtask

  task automatic run_vec(input int i);
    step(vecs[i].r, vecs[i].e, vecs[i].u, vecs[i].l,
         vecs[i].lv, vecs[i].lim);
    check($sformatf("vec%0d", i), vecs[i].ec, vecs[i].et, vecs[i].ee);
  endtask

  initial begin
    int v;
    logic t;
    checks   = 0;
    errors   = 0;
    reset    = 1'b0;
    en       = 1'b0;
    up       = 1'b1;
    load     = 1'b0;
    load_val = 8'h00;
    limit    = 8'h59;

    for (int i = 0; i < 5; i++)
      vecs[i] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h59, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h59, 8'h01, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h59, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h45, 8'h59, 8'h45, 1'b0, 1'b0};
    for (int i = 8; i < 18; i++)
      vecs[i] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h59, 8'h45, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h20, 8'h00, 1'b1, 1'b0};
    vecs[19] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h20, 8'h01, 1'b0, 1'b0};
    vecs[20] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h2F, 8'h01, 1'b0, 1'b1};
    vecs[21] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h37, 8'h59, 8'h37, 1'b0, 1'b1};
    vecs[22] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h12, 8'h59, 8'h00, 1'b0, 1'b0};
    vecs[23] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h57, 8'h59, 8'h57, 1'b0, 1'b0};
    vecs[24] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 8'h59, 8'h57, 1'b0, 1'b1};
    vecs[25] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h70, 8'h59, 8'h57, 1'b0, 1'b1};
    vecs[26] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 8'h59, 8'h12, 1'b0, 1'b1};
    vecs[27] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[28] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[29] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[30] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h59, 8'h59, 1'b1, 1'b1};
    vecs[31] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h59, 8'h58, 1'b0, 1'b1};
    vecs[32] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h12, 8'h5F, 8'h58, 1'b0, 1'b1};
    vecs[33] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h30, 8'h00, 1'b1, 1'b1};
    vecs[34] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h25, 8'h30, 8'h25, 1'b0, 1'b1};
    vecs[35] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h20, 8'h24, 1'b0, 1'b1};

    for (int i = 0; i < 7; i++)
      run_vec(i);

    v = 0;
    for (int k = 0; k < 61; k++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h59);
      v = (v >= 59) ? 0 : v + 1;
      t = (v == 0);
      check($sformatf("up%0d", k), to_bcd(v), t, 1'b0);
    end

    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 8'h23);
    check("ld11", 8'h11, 1'b0, 1'b0);
    v = 11;
    for (int k = 0; k < 14; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h23);
      if (v == 0) begin
        v = 23;
        t = 1'b1;
      end else begin
        v = v - 1;
        t = 1'b0;
      end
      check($sformatf("dn%0d", k), to_bcd(v), t, 1'b0);
    end

    for (int i = 7; i < 36; i++)
      run_vec(i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
